// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-7 latching demultiplexer:
// FSM state encoding, slot count and the reserved invalid slot address.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam int         NUM_SLOTS   = 7;
  localparam logic [2:0] SEL_INVALID = 3'b111;

  // Auto-increment pointer step: walks 0..NUM_SLOTS-1 and wraps to 0.
  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == 3'(NUM_SLOTS - 1)) ? 3'b000 : p + 3'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer for an asynchronous level input.
// DEPTH flops in series, all cleared by the asynchronous active-low reset.
module sync_bit #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/demux_1_to_7_latch.sv
// 1-to-7 latching demultiplexer: an asynchronous WrEn level is synchronized,
// turned into exactly one write per high period, and Din lands in slot Sel.
// Optional build macro DEMUX_AUTOINC_EN: ignore Sel and write to a wrapping pointer.
module demux_1_to_7_latch
  import demux_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Din,
  input  logic [2:0]           Sel,
  input  logic                 WrEn,
  input  logic                 Clear,
  output logic [NUM_SLOTS-1:0] Out,
  output logic [NUM_SLOTS-1:0] Valid,
  output logic                 Error,
  output logic [2:0]           Ptr
);

  logic                 wr_s;
  state_t               state;
  logic                 fire;
  logic [2:0]           tgt;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic [NUM_SLOTS-1:0] out_q;
  logic [NUM_SLOTS-1:0] valid_q;
  logic                 error_q;

  sync_bit #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (Clock),
    .rst_n (Resetn),
    .d     (WrEn),
    .q     (wr_s)
  );

  // Edge detector on the synchronized level: WRITE lasts exactly one cycle,
  // HOLD waits for the level to drop so a long press yields a single write.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (wr_s) state <= WRITE;
        WRITE:   state <= HOLD;
        HOLD:    if (!wr_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign fire = (state == WRITE);

`ifdef DEMUX_AUTOINC_EN
  logic [2:0] ptr_q;
  logic       unused_sel;

  assign unused_sel = ^Sel;
  assign tgt        = ptr_q;
  assign Ptr        = ptr_q;
`else
  assign tgt = Sel;
  assign Ptr = 3'b000;
`endif

  // NOTE: every signal driven in always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    slot_hit = '0;
    if (fire && tgt != SEL_INVALID) begin
      slot_hit = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << tgt;
    end
  end

  // NOTE: the slot bank is only seven flops and drives outputs directly, so it
  // is reset like ordinary control state rather than left uninitialised.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      out_q   <= '0;
      valid_q <= '0;
      error_q <= 1'b0;
`ifdef DEMUX_AUTOINC_EN
      ptr_q   <= 3'b000;
`endif
    end else if (Clear) begin
      // Clear takes priority over a coinciding write; the FSM keeps running.
      out_q   <= '0;
      valid_q <= '0;
      error_q <= 1'b0;
`ifdef DEMUX_AUTOINC_EN
      ptr_q   <= 3'b000;
`endif
    end else begin
      out_q   <= (out_q & ~slot_hit) | (slot_hit & {NUM_SLOTS{Din}});
      valid_q <= valid_q | slot_hit;
`ifdef DEMUX_AUTOINC_EN
      if (fire) ptr_q <= next_ptr(ptr_q);
`else
      if (fire && tgt == SEL_INVALID) error_q <= 1'b1;
`endif
    end
  end

  assign Out   = out_q;
  assign Valid = valid_q;
  assign Error = error_q;

endmodule

// File: tb/tb_demux_1_to_7_latch.sv
// Self-checking bench for demux_1_to_7_latch: directed scenarios plus random
// press sequences checked against a slot-level behavioural model.
module tb_demux_1_to_7_latch;

  localparam int SYNC = 2;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Din;
  logic [2:0] Sel;
  logic       WrEn;
  logic       Clear;
  logic [6:0] Out;
  logic [6:0] Valid;
  logic       Error;
  logic [2:0] Ptr;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: seven slots, their written flags, sticky error, pointer.
  bit [6:0] m_out;
  bit [6:0] m_valid;
  bit       m_err;
  int       m_ptr;

  demux_1_to_7_latch #(.SYNC_STAGES(SYNC)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Din    (Din),
    .Sel    (Sel),
    .WrEn   (WrEn),
    .Clear  (Clear),
    .Out    (Out),
    .Valid  (Valid),
    .Error  (Error),
    .Ptr    (Ptr)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic void model_clear();
    m_out = '0; m_valid = '0; m_err = 1'b0; m_ptr = 0;
  endfunction

  function automatic void model_write(input int sel, input bit din);
`ifdef DEMUX_AUTOINC_EN
    m_out[m_ptr]   = din;
    m_valid[m_ptr] = 1'b1;
    m_ptr          = (m_ptr + 1) % 7;
`else
    if (sel == 7) m_err = 1'b1;
    else begin
      m_out[sel]   = din;
      m_valid[sel] = 1'b1;
    end
`endif
  endfunction

  function automatic logic [17:0] model_vec();
    return {m_out, m_valid, m_err, 3'(m_ptr)};
  endfunction

  // One press: hold WrEn for len cycles, then low long enough to return to IDLE.
  task automatic press(input logic [2:0] s, input logic d, input int len);
    Sel = s; Din = d; WrEn = 1'b1;
    repeat (len) tick();
    WrEn = 1'b0;
    repeat (SYNC + 4) tick();
    model_write(int'(s), d);
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    Resetn = 1'b0; WrEn = 1'b0; Din = 1'b0; Sel = 3'd0; Clear = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if ({Out, Valid, Error, Ptr} !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_state: got out=%b valid=%b err=%b ptr=%0d, want all zero",
               Out, Valid, Error, Ptr);
    end
    repeat (3) tick();
    Resetn = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({Out, Valid, Error, Ptr} !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: got out=%b valid=%b err=%b ptr=%0d, want all zero",
               Out, Valid, Error, Ptr);
    end
  endtask

  task automatic test_latency();
    do_clear();
    Sel = 3'd3; Din = 1'b1; WrEn = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == SYNC + 2) model_write(3, 1'b1);
      if (e == SYNC + 2) Din = 1'b0;  // a second write would now clear slot 3
      n_checks++;
      if ({Out, Valid} !== {m_out, m_valid}) begin
        n_fail++;
        $display("FAIL latency_edge%0d: got out=%b valid=%b, want out=%b valid=%b",
                 e, Out, Valid, m_out, m_valid);
      end
    end
    WrEn = 1'b0;
    repeat (SYNC + 4) tick();
    n_checks++;
    if ({Out, Valid} !== {7'b0001000, 7'b0001000}) begin
      n_fail++;
      $display("FAIL latency_final: got out=%b valid=%b, want out=0001000 valid=0001000",
               Out, Valid);
    end
  endtask

  task automatic test_sweep();
    do_clear();
    for (int k = 0; k < 7; k++) press(3'(k), 1'b1, 2 + k);
    press(3'd2, 1'b0, 3);
    n_checks++;
    if ({Out, Valid, Error} !== {7'b1111011, 7'b1111111, 1'b0}) begin
      n_fail++;
      $display("FAIL sweep: got out=%b valid=%b err=%b, want out=1111011 valid=1111111 err=0",
               Out, Valid, Error);
    end
  endtask

  task automatic test_invalid();
    press(3'd7, 1'b1, 3);
    n_checks++;
    if ({Out, Valid, Error} !== {7'b1111011, 7'b1111111, 1'b1}) begin
      n_fail++;
      $display("FAIL invalid_sel: got out=%b valid=%b err=%b, want out=1111011 valid=1111111 err=1",
               Out, Valid, Error);
    end
    press(3'd2, 1'b1, 2);
    n_checks++;
    if ({Out, Error} !== {7'b1111111, 1'b1}) begin
      n_fail++;
      $display("FAIL error_sticky: got out=%b err=%b, want out=1111111 err=1", Out, Error);
    end
    do_clear();
    n_checks++;
    if ({Out, Valid, Error} !== 15'd0) begin
      n_fail++;
      $display("FAIL error_clear: got out=%b valid=%b err=%b, want all zero", Out, Valid, Error);
    end
  endtask

  task automatic test_clear_in_write();
    press(3'd1, 1'b1, 2);  // give Clear something to wipe
    Sel = 3'd5; Din = 1'b1; WrEn = 1'b1;
    repeat (SYNC + 1) tick();  // now in the WRITE cycle
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    model_clear();
    n_checks++;
    if ({Out, Valid, Error, Ptr} !== model_vec()) begin
      n_fail++;
      $display("FAIL clear_wins: got out=%b valid=%b err=%b ptr=%0d, want all zero",
               Out, Valid, Error, Ptr);
    end
    repeat (4) tick();
    n_checks++;
    if ({Out, Valid} !== 14'd0) begin
      n_fail++;
      $display("FAIL clear_no_rewrite: got out=%b valid=%b, want zero", Out, Valid);
    end
    WrEn = 1'b0;
    repeat (SYNC + 4) tick();
    press(3'd5, 1'b1, 2);
    n_checks++;
    if ({Out, Valid, Error, Ptr} !== model_vec()) begin
      n_fail++;
      $display("FAIL clear_recover: got out=%b valid=%b err=%b ptr=%0d, want out=%b valid=%b",
               Out, Valid, Error, Ptr, m_out, m_valid);
    end
  endtask

  task automatic test_reset_in_hold();
    Sel = 3'd1; Din = 1'b1; WrEn = 1'b1;
    repeat (SYNC + 4) tick();  // write done, FSM in HOLD
    Resetn = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if ({Out, Valid, Error, Ptr} !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_async: got out=%b valid=%b err=%b ptr=%0d, want all zero",
               Out, Valid, Error, Ptr);
    end
    repeat (2) tick();
    Sel = 3'd6;
    Resetn = 1'b1;
    for (int e = 1; e <= SYNC + 2; e++) begin
      tick();
      if (e == SYNC + 2) model_write(6, 1'b1);
      n_checks++;
      if ({Out, Valid, Error, Ptr} !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_release_edge%0d: got out=%b valid=%b ptr=%0d, want out=%b valid=%b ptr=%0d",
                 e, Out, Valid, Ptr, m_out, m_valid, m_ptr);
      end
    end
    WrEn = 1'b0;
    repeat (SYNC + 4) tick();
  endtask

  task automatic test_autoinc();
    do_clear();
    for (int i = 0; i < 8; i++) begin
      press(3'($urandom_range(0, 7)), 1'b1, 2 + (i % 3));
      n_checks++;
      if ({Out, Valid, Error, Ptr} !== model_vec()) begin
        n_fail++;
        $display("FAIL autoinc_%0d: got out=%b err=%b ptr=%0d, want out=%b err=0 ptr=%0d",
                 i, Out, Error, Ptr, m_out, m_ptr);
      end
    end
    n_checks++;
    if ({Out, Ptr} !== {7'b1111111, 3'd1}) begin
      n_fail++;
      $display("FAIL autoinc_final: got out=%b ptr=%0d, want out=1111111 ptr=1", Out, Ptr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) do_clear();
      else press(3'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(2, 8)));
      n_checks++;
      if ({Out, Valid, Error, Ptr} !== model_vec()) begin
        n_fail++;
        $display("FAIL random_%0d: got out=%b valid=%b err=%b ptr=%0d, want out=%b valid=%b err=%b ptr=%0d",
                 i, Out, Valid, Error, Ptr, m_out, m_valid, m_err, m_ptr);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef DEMUX_AUTOINC_EN
    test_autoinc();
`else
    test_latency();
    test_sweep();
    test_invalid();
`endif
    test_clear_in_write();
    test_reset_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1_to_7_latch.md
DEMUX_1_TO_7_LATCH -- requirements
Module: demux_1_to_7_latch

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on WrEn (legal range 2..4).
REQ-002 Clock  input  1  SHALL be the single clock; all state is on its rising edge.
REQ-003 Resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Din  input  1  SHALL be the data bit written into the selected slot.
REQ-005 Sel  input  3  SHALL be the slot address; 0..6 are valid, 3'b111 is invalid.
REQ-006 WrEn  input  1  SHALL be the asynchronous, active-high write request (level, e.g. from a key).
REQ-007 Clear  input  1  SHALL be the synchronous clear of all slots and flags.
REQ-008 Out  output  7  SHALL hold the latched slot values; Out[k] is slot k.
REQ-009 Valid  output  7  SHALL flag slots written since the last reset or Clear.
REQ-010 Error  output  1  SHALL be a sticky flag for attempted writes to Sel=3'b111.
REQ-011 Ptr  output  3  SHALL expose the auto-increment pointer (see Configuration).

Function
REQ-012 WrEn SHALL pass through SYNC_STAGES flops; the last flop output is wr_s.
REQ-013 The FSM SHALL have states IDLE, WRITE and HOLD.
REQ-014 Transitions: IDLE->WRITE when wr_s=1; WRITE->HOLD unconditionally; HOLD->IDLE when wr_s=0; otherwise the state holds.
REQ-015 The write SHALL occur only on the clock edge ending the single WRITE cycle; Din and Sel are sampled on that edge.
REQ-016 Latency: with WrEn high from before edge 1, Out SHALL update after edge SYNC_STAGES+2 (edge 4 at the default).
REQ-017 One WrEn high period SHALL produce exactly one write, regardless of its length.
REQ-018 A WRITE to Sel=k (0..6) SHALL set Out[k]=Din and Valid[k]=1; other slots remain unchanged.
REQ-019 A WRITE to Sel=3'b111 SHALL leave Out and Valid unchanged and set Error=1 until reset or Clear.
REQ-020 Clear=1 SHALL zero Out, Valid, Error and Ptr on the next edge; the FSM and synchronizer are unaffected.
REQ-021 If Clear coincides with a WRITE cycle, Clear SHALL win and the write is discarded.
REQ-022 A WrEn pulse shorter than one clock period MAY be missed; a pulse of at least 2 clock periods high SHALL be captured.

Reset
REQ-023 Resetn=0 SHALL immediately force Out=0, Valid=0, Error=0, Ptr=0, all synchronizer flops to 0 and the FSM to IDLE.
REQ-024 Reset asserted mid-operation (WRITE or HOLD) SHALL abandon the write in progress.
REQ-025 If WrEn is held high across reset release, exactly one write SHALL follow, SYNC_STAGES+2 edges after release.

Configuration
REQ-026 Macro DEMUX_AUTOINC_EN defined: Sel SHALL be ignored and each write targets slot Ptr.
REQ-027 With DEMUX_AUTOINC_EN, Ptr SHALL advance by one after each write and wrap from 6 to 0; Error is never set.
REQ-028 Macro DEMUX_AUTOINC_EN undefined: Ptr SHALL be tied to 3'b000 and Sel addressing applies as above.

Structure
REQ-029 The shared package demux_pkg SHALL hold the state encodings (IDLE=2'b00, WRITE=2'b01, HOLD=2'b10), NUM_SLOTS=7 and SEL_INVALID=3'b111.
REQ-030 The synchronizer SHALL be a sub-module sync_bit, parameterized by depth, with async active-low reset.
REQ-031 The FSM and slot registers SHALL live in demux_1_to_7_latch; there are no other sub-modules.

Verification
REQ-032 Reset, then Sel=3, Din=1, WrEn high for 10 cycles -> Out=7'b0001000 and Valid=7'b0001000 after edge 4; no second write while WrEn stays high.
REQ-033 Writes Din=1 to Sel=0..6 in turn, then Din=0 to Sel=2 -> Out=7'b1111011, Valid=7'b1111111.
REQ-034 Sel=7, WrEn pulse -> Out and Valid unchanged, Error=1; Error stays 1 after further valid writes; Clear -> Error=0.
REQ-035 Clear asserted in the WRITE cycle of a Sel=5, Din=1 write -> Out=0, Valid=0; the FSM still goes to HOLD.
REQ-036 Resetn pulsed low during HOLD with WrEn high -> outputs 0 at once, then one write 4 edges after release.
REQ-037 DEMUX_AUTOINC_EN build, 8 writes with Din=1 -> Ptr sequence 1,2,3,4,5,6,0,1; Out=7'b1111111; Sel ignored.
